// File: rtl/exec_unit_if.sv
// Operation request / result bundle between the decode stage and exec_unit.
interface exec_unit_if;
  logic        valid_in;
  logic [3:0]  Aluop;
  logic [1:0]  SHTOp;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [4:0]  shamt;
  logic        shvar;
  logic        mfhi;
  logic        mflo;
  logic [31:0] result;
  logic        valid_out;
  logic        overflow;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  // Decoder side: presents operations, observes results.
  modport master (
    output valid_in, Aluop, SHTOp, srca, srcb, shamt, shvar, mfhi, mflo,
    input  result, valid_out, overflow, busy, hi, lo
  );

  // Execution side: consumes operations, produces results.
  modport slave (
    input  valid_in, Aluop, SHTOp, srca, srcb, shamt, shvar, mfhi, mflo,
    output result, valid_out, overflow, busy, hi, lo
  );
endinterface

// File: rtl/exec_unit.sv
// Integer execution unit: single-cycle ALU/shifter with a registered result,
// plus an iterative (1 bit per cycle, 32 cycles) multiply/divide unit that
// owns the architectural HI/LO pair.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | accepting operations; single-cycle results land next edge
// S_MD    | multiply/divide iterating; busy high, new ops held upstream
module exec_unit (
  input  logic     clk,
  input  logic     reset,
  exec_unit_if.slave bus
);

  localparam logic [3:0] OP_ADDU = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUBU = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NOR  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_MULT = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;
  localparam logic [1:0] SH_SRA = 2'b11;

  typedef enum logic {S_IDLE, S_MD} state_t;

  state_t      r_state;
  logic [31:0] r_result;
  logic        r_valid_out;
  logic        r_overflow;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [5:0]  r_count;

  // Multiply/divide working state, latched at acceptance.
  logic        r_is_div;
  logic        r_neg_q;     // negate product (mult) or quotient (div)
  logic        r_neg_r;     // negate remainder (signed dividend was negative)
  logic        r_div0;
  logic [31:0] r_src_a;     // original dividend, reported as HI on divide by zero
  logic [31:0] r_opb;       // multiplicand magnitude or divisor magnitude
  logic [31:0] r_acc_hi;    // partial product high / partial remainder
  logic [31:0] r_acc_lo;    // multiplier shifting out / dividend shifting out, quotient in

  logic [4:0]  w_amt;
  logic        w_is_md;
  logic        w_md_signed;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_result;
  logic        w_overflow;

  logic [32:0] w_mul_sum;
  logic [32:0] w_rem_sh;
  logic [32:0] w_rem_sub;
  logic        w_q_bit;
  logic [31:0] w_step_hi;
  logic [31:0] w_step_lo;
  logic [63:0] w_prod_fix;
  logic [31:0] w_fin_hi;
  logic [31:0] w_fin_lo;

  assign w_amt       = bus.shvar ? bus.srca[4:0] : bus.shamt;
  assign w_sum       = bus.srca + bus.srcb;
  assign w_diff      = bus.srca - bus.srcb;
  assign w_md_signed = (bus.Aluop == OP_MULT) || (bus.Aluop == OP_DIV);
  assign w_abs_a     = (w_md_signed && bus.srca[31]) ? (32'd0 - bus.srca) : bus.srca;
  assign w_abs_b     = (w_md_signed && bus.srcb[31]) ? (32'd0 - bus.srcb) : bus.srcb;
  assign w_is_md     = !bus.mfhi && !bus.mflo && (bus.SHTOp == 2'b00) &&
                       ((bus.Aluop == OP_MULT) || (bus.Aluop == OP_MULU) ||
                        (bus.Aluop == OP_DIV)  || (bus.Aluop == OP_DIVU));

  // Single-cycle result select: mfhi > mflo > shifter > ALU.
  always_comb begin
    w_result   = 32'd0;
    w_overflow = 1'b0;
    if (bus.mfhi) begin
      w_result = r_hi;
    end else if (bus.mflo) begin
      w_result = r_lo;
    end else if (bus.SHTOp != 2'b00) begin
      case (bus.SHTOp)
        SH_SLL:  w_result = bus.srcb << w_amt;
        SH_SRL:  w_result = bus.srcb >> w_amt;
        SH_SRA:  w_result = $unsigned($signed(bus.srcb) >>> w_amt);
        default: w_result = 32'd0;
      endcase
    end else begin
      case (bus.Aluop)
        OP_ADDU: w_result = w_sum;
        OP_ADD: begin
          w_result   = w_sum;
          w_overflow = (bus.srca[31] == bus.srcb[31]) && (w_sum[31] != bus.srca[31]);
        end
        OP_SUBU: w_result = w_diff;
        OP_SUB: begin
          w_result   = w_diff;
          w_overflow = (bus.srca[31] != bus.srcb[31]) && (w_diff[31] != bus.srca[31]);
        end
        OP_AND:  w_result = bus.srca & bus.srcb;
        OP_OR:   w_result = bus.srca | bus.srcb;
        OP_NOR:  w_result = ~(bus.srca | bus.srcb);
        OP_XOR:  w_result = bus.srca ^ bus.srcb;
        OP_SLTU: w_result = {31'd0, (bus.srca < bus.srcb)};
        OP_SLT:  w_result = {31'd0, ($signed(bus.srca) < $signed(bus.srcb))};
        OP_LUI:  w_result = {bus.srcb[15:0], 16'h0000};
        default: w_result = 32'd0;
      endcase
    end
  end

  // One shift-add (multiply) or restoring-subtract (divide) step on magnitudes.
  always_comb begin
    w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : 33'd0);
    w_rem_sh  = {r_acc_hi, r_acc_lo[31]};
    w_rem_sub = w_rem_sh - {1'b0, r_opb};
    w_q_bit   = !w_rem_sub[32];
    if (r_is_div) begin
      w_step_hi = w_q_bit ? w_rem_sub[31:0] : w_rem_sh[31:0];
      w_step_lo = {r_acc_lo[30:0], w_q_bit};
    end else begin
      w_step_hi = w_mul_sum[32:1];
      w_step_lo = {w_mul_sum[0], r_acc_lo[31:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied on the final step.
  always_comb begin
    w_prod_fix = r_neg_q ? (64'd0 - {w_step_hi, w_step_lo}) : {w_step_hi, w_step_lo};
    w_fin_hi   = w_prod_fix[63:32];
    w_fin_lo   = w_prod_fix[31:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fin_hi = r_src_a;
        w_fin_lo = 32'hFFFF_FFFF;
      end else begin
        w_fin_hi = r_neg_r ? (32'd0 - w_step_hi) : w_step_hi;
        w_fin_lo = r_neg_q ? (32'd0 - w_step_lo) : w_step_lo;
      end
    end
  end

  // Control FSM with registered outputs; reset overrides accepts and completions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_result    <= 32'd0;
      r_valid_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_count     <= 6'd0;
      r_is_div    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      r_src_a     <= 32'd0;
      r_opb       <= 32'd0;
      r_acc_hi    <= 32'd0;
      r_acc_lo    <= 32'd0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid_in) begin
            if (w_is_md) begin
              r_state  <= S_MD;
              r_busy   <= 1'b1;
              r_count  <= 6'd0;
              r_is_div <= bus.Aluop[2];
              r_neg_q  <= w_md_signed && (bus.srca[31] ^ bus.srcb[31]);
              r_neg_r  <= w_md_signed && bus.srca[31];
              r_div0   <= (bus.srcb == 32'd0);
              r_src_a  <= bus.srca;
              r_acc_hi <= 32'd0;
              if (bus.Aluop[2]) begin
                r_opb    <= w_abs_b;
                r_acc_lo <= w_abs_a;
              end else begin
                r_opb    <= w_abs_a;
                r_acc_lo <= w_abs_b;
              end
            end else begin
              r_result    <= w_result;
              r_overflow  <= w_overflow;
              r_valid_out <= 1'b1;
            end
          end
        end
        S_MD: begin
          r_acc_hi <= w_step_hi;
          r_acc_lo <= w_step_lo;
          if (r_count == 6'd31) begin
            r_hi    <= w_fin_hi;
            r_lo    <= w_fin_lo;
            r_busy  <= 1'b0;
            r_count <= 6'd0;
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + 6'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result    = r_result;
  assign bus.valid_out = r_valid_out;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = r_busy;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit.
`timescale 1ns/1ps
module tb_exec_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  exec_unit_if bus();

  exec_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_in = 1'b0;
    bus.Aluop    = 4'd0;
    bus.SHTOp    = 2'd0;
    bus.srca     = 32'd0;
    bus.srcb     = 32'd0;
    bus.shamt    = 5'd0;
    bus.shvar    = 1'b0;
    bus.mfhi     = 1'b0;
    bus.mflo     = 1'b0;
  endtask

  task automatic set_op(input logic [3:0] aluop, input logic [1:0] sht,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sa, input logic sv,
                        input logic fhi, input logic flo);
    bus.valid_in = 1'b1;
    bus.Aluop    = aluop;
    bus.SHTOp    = sht;
    bus.srca     = a;
    bus.srcb     = b;
    bus.shamt    = sa;
    bus.shvar    = sv;
    bus.mfhi     = fhi;
    bus.mflo     = flo;
  endtask

  // Accept an MD op, scramble operands afterwards, count edges until busy drops.
  task automatic run_md(input logic [3:0] aluop, input logic [31:0] a,
                        input logic [31:0] b, output int cycles, output logic busy_at_accept);
    set_op(aluop, 2'b00, a, b, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    busy_at_accept = bus.busy;
    idle();
    bus.srca = 32'hDEAD_BEEF;
    bus.srcb = 32'h1234_5678;
    cycles = 0;
    while (bus.busy && cycles < 40) begin
      step();
      cycles++;
    end
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_op(4'b0001, 2'b00, 32'h7FFF_FFFF, 32'h1, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    n_checks++;
    if (bus.result !== 32'd0 || bus.valid_out !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got res=%h vo=%b ov=%b busy=%b hi=%h lo=%h required all zero",
               bus.result, bus.valid_out, bus.overflow, bus.busy, bus.hi, bus.lo);
    end
    reset = 1'b0;
    idle();
    step();
  endtask

  task automatic test_add_overflow();
    logic [3:0]  op  [4] = '{4'b0001, 4'b0000, 4'b0011, 4'b0010};
    logic [31:0] a   [4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b   [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] exp [4] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    logic        ov  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_op(op[i], 2'b00, a[i], b[i], 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      n_checks++;
      if (bus.result !== exp[i] || bus.overflow !== ov[i] || bus.valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL addsub[%0d]: got res=%h ov=%b vo=%b required res=%h ov=%b vo=1",
                 i, bus.result, bus.overflow, bus.valid_out, exp[i], ov[i]);
      end
    end
    idle();
    step();
    n_checks++;
    if (bus.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid: got vo=%b required 0", bus.valid_out);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  op  [10] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1001,
                             4'b1000, 4'b1110, 4'b1111, 4'b1001, 4'b0000};
    logic [31:0] a   [10] = '{32'hA5A5_0F0F, 32'h0000_FF00, 32'h0, 32'hFFFF_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h5, 32'hFFFF_FFFF};
    logic [31:0] b   [10] = '{32'hFFFF_00FF, 32'h00FF_0000, 32'h0, 32'h0F0F_0F0F, 32'h1,
                             32'h1, 32'hABCD_1234, 32'h9ABC_DEF0, 32'h5, 32'h1};
    logic [31:0] exp [10] = '{32'hA5A5_000F, 32'h00FF_FF00, 32'hFFFF_FFFF, 32'hF0F0_0F0F, 32'h1,
                             32'h0, 32'h1234_0000, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      set_op(op[i], 2'b00, a[i], b[i], 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      n_checks++;
      if (bus.result !== exp[i] || bus.valid_out !== 1'b1 || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL alu[%0d] op=%b: got res=%h vo=%b ov=%b required res=%h vo=1 ov=0",
                 i, op[i], bus.result, bus.valid_out, bus.overflow, exp[i]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_shifts();
    logic [1:0]  sh  [5] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
    logic [31:0] a   [5] = '{32'h0, 32'h8, 32'h0, 32'h0, 32'h3};
    logic [31:0] b   [5] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h1, 32'h4};
    logic [4:0]  sa  [5] = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd0};
    logic        sv  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] exp [5] = '{32'hFF00_0000, 32'hFFF0_0000, 32'h0F00_0000, 32'h8000_0000, 32'h7};
    for (int i = 0; i < 5; i++) begin
      // Aluop = sub with overflow-prone operands is shadowed by any shift.
      set_op((sh[i] == 2'b00) ? 4'b0000 : 4'b0011, sh[i], a[i], b[i], sa[i], sv[i], 1'b0, 1'b0);
      step();
      n_checks++;
      if (bus.result !== exp[i] || bus.valid_out !== 1'b1 || bus.overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL shift[%0d]: got res=%h vo=%b ov=%b required res=%h vo=1 ov=0",
                 i, bus.result, bus.valid_out, bus.overflow, exp[i]);
      end
    end
    idle();
    step();
  endtask

  task automatic test_mult();
    int   cyc;
    logic b0;
    run_md(4'b1010, 32'hFFFF_FFFE, 32'h3, cyc, b0);
    n_checks++;
    if (b0 !== 1'b1 || cyc !== 32) begin
      n_fail++;
      $display("FAIL mult_busy: got busy_at_accept=%b cycles=%0d required 1 and 32", b0, cyc);
    end
    n_checks++;
    if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL mult: got hi=%h lo=%h required hi=ffffffff lo=fffffffa", bus.hi, bus.lo);
    end
    run_md(4'b1011, 32'hFFFF_FFFE, 32'h3, cyc, b0);
    n_checks++;
    if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA || cyc !== 32) begin
      n_fail++;
      $display("FAIL multu: got hi=%h lo=%h cycles=%0d required hi=2 lo=fffffffa 32",
               bus.hi, bus.lo, cyc);
    end
    // mflo wins over a shift request; mfhi wins over mflo.
    set_op(4'b0000, 2'b01, 32'h0, 32'h1, 5'd1, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFA || bus.valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL mflo: got res=%h vo=%b required fffffffa 1", bus.result, bus.valid_out);
    end
    set_op(4'b1010, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1);
    step();
    n_checks++;
    if (bus.result !== 32'h2 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mfhi: got res=%h busy=%b required 2 0", bus.result, bus.busy);
    end
    idle();
    step();
  endtask

  task automatic test_div();
    logic [3:0]  op [4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000, 32'd100};
    logic [31:0] b  [4] = '{32'h2, 32'h0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'd2};
    logic [31:0] el [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'd14};
    int   cyc;
    logic b0;
    for (int i = 0; i < 4; i++) begin
      run_md(op[i], a[i], b[i], cyc, b0);
      n_checks++;
      if (bus.hi !== eh[i] || bus.lo !== el[i] || cyc !== 32 || b0 !== 1'b1) begin
        n_fail++;
        $display("FAIL div[%0d]: got hi=%h lo=%h cycles=%0d busy0=%b required hi=%h lo=%h 32 1",
                 i, bus.hi, bus.lo, cyc, b0, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic seen_vo;
    set_op(4'b1011, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    set_op(4'b0001, 2'b00, 32'd5, 32'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    seen_vo = 1'b0;
    while (bus.busy && cyc < 40) begin
      step();
      cyc++;
      if (bus.valid_out) seen_vo = 1'b1;
    end
    n_checks++;
    if (seen_vo !== 1'b0 || cyc !== 32) begin
      n_fail++;
      $display("FAIL held_add: got early_valid=%b cycles=%0d required 0 and 32", seen_vo, cyc);
    end
    step();
    n_checks++;
    if (bus.result !== 32'd11 || bus.valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL add_after_busy: got res=%h vo=%b required b 1", bus.result, bus.valid_out);
    end
    set_op(4'b0000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++;
    if (bus.result !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL mfhi_new: got res=%h lo=%h required fffffffe 00000001", bus.result, bus.lo);
    end
    idle();
    step();
  endtask

  task automatic test_reset_mid_div();
    set_op(4'b1101, 2'b00, 32'd100, 32'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    repeat (9) step();
    reset = 1'b1;
    set_op(4'b0000, 2'b00, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_div: got busy=%b hi=%h lo=%h vo=%b required 0 0 0 0",
               bus.busy, bus.hi, bus.lo, bus.valid_out);
    end
    reset = 1'b0;
    idle();
    repeat (40) step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_fail++;
      $display("FAIL no_late_update: got busy=%b hi=%h lo=%h required 0 0 0",
               bus.busy, bus.hi, bus.lo);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    step();
    test_reset();
    test_add_overflow();
    test_alu();
    test_shifts();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high; ports clk, reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 valid_in  in  1  operation presented this cycle.
REQ-005 Aluop  in  4  ALU code from decoder: 0000 addu, 0001 add, 0010 subu, 0011 sub, 0100 and, 0101 or, 0110 nor, 0111 xor, 1000 sltu, 1001 slt, 1010 mult, 1011 multu, 1100 div, 1101 divu, 1110 lui, 1111 invalid.
REQ-006 SHTOp  in  2  shift code from decoder: 00 none, 01 sll, 10 srl, 11 sra.
REQ-007 srca, srcb  in  32 each  operands (rs, rt/immediate).
REQ-008 shamt  in  5  instruction shift amount; shvar  in  1  selects srca[4:0] as amount instead.
REQ-009 mfhi, mflo  in  1 each  read HI / LO as result.
REQ-010 result  out  32  registered result; valid_out  out  1  result valid; overflow  out  1  signed overflow of accepted add/sub.
REQ-011 busy  out  1  multiply/divide in progress; hi, lo  out  32 each  architectural HI/LO.

Function
REQ-012 Accept: op accepted on rising edge when valid_in=1 and busy=0; valid_in while busy=1 ignored, upstream holds it.
REQ-013 Result priority: mfhi > mflo > SHTOp!=00 > Aluop.
REQ-014 Single-cycle ops: result, overflow, valid_out registered on accepting edge; latency 1 cycle; valid_out=0 on any edge with no accepted single-cycle op.
REQ-015 Shifts operate on srcb; amount = shvar ? srca[4:0] : shamt; sra sign-fills from srcb[31].
REQ-016 add/sub: result = 32-bit wrapped value; overflow=1 iff signed overflow; overflow=0 for all other ops; addu/subu never flag.
REQ-017 slt signed, sltu unsigned compare srca<srcb, result 0 or 1; lui result = {srcb[15:0],16'h0}.
REQ-018 Aluop=1111 with SHTOp=00 and no mfhi/mflo: result=0, valid_out=1.
REQ-019 MD ops (1010-1101, SHTOp=00): no valid_out; busy rises on accepting edge, held exactly 32 cycles; iterative unit, 1 bit per cycle, 6-bit step counter.
REQ-020 MD completion: on 32nd edge after acceptance hi/lo written and busy falls same edge; new op acceptable next edge.
REQ-021 mult/multu: {hi,lo} = 64-bit signed/unsigned product.
REQ-022 div/divu: lo=quotient, hi=remainder; signed: quotient truncates toward zero, remainder takes dividend sign.
REQ-023 Divide by zero: lo=32'hFFFFFFFF, hi=srca; still 32-cycle latency.
REQ-024 Signed div 32'h80000000 / -1: lo=32'h80000000, hi=0, no flag.
REQ-025 mfhi/mflo read hi/lo as at the accepting edge; never issued during busy (REQ-012).
REQ-026 MD operands latched at acceptance; later srca/srcb changes do not affect the result.

Reset
REQ-027 Reset on edge: result=0, valid_out=0, overflow=0, busy=0, hi=0, lo=0, counter=0; in-flight MD aborted, hi/lo not updated; valid_in on reset edge ignored.
REQ-028 Reset has priority over all accepts and completions on the same edge.

Verification
REQ-029 add srca=7FFFFFFF srcb=1 -> next cycle result=80000000, overflow=1, valid_out=1; addu same -> overflow=0.
REQ-030 sra srcb=F0000000 shamt=4; srav with shvar=1 srca=8 -> results FF000000 then FFF00000.
REQ-031 mult srca=FFFFFFFE srcb=3 -> busy 32 cycles, then hi=FFFFFFFF lo=FFFFFFFA; multu same -> hi=2 lo=FFFFFFFA.
REQ-032 div srca=FFFFFFF9 (-7) srcb=2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu srcb=0 -> lo=FFFFFFFF, hi=srca.
REQ-033 valid_in add held during busy -> ignored until busy falls, then accepted; mfhi right after completion returns new hi.
REQ-034 reset at cycle 10 of div -> busy=0, hi=lo=0 next cycle, no later update.
